fifo_wr_feeder: RTL
===================

Name: fifo_wr_feeder

Overview:
- Write-domain producer that sits in front of the async FIFO write controller and drives its write port (w_inc, write data) from an upstream valid/ready stream.
- Decodes the synchronized gray read pointer to binary and keeps its own binary write count, which gives an exact fill level and almost-full indication in the w_clk domain.
- Has a 2-entry skid buffer, so upstream backpressure is registered and no beat is ever dropped or written into a full FIFO.

Parameters:
- D_SIZE, 8, data width of stream and FIFO write data.
- P_SIZE, 4, FIFO pointer width; FIFO depth DEPTH = 2^(P_SIZE-1) = 8.
- AF_THRESH, 6, fill level at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- w_clk  input  1  write-domain clock.
- w_rstn  input  1  write-domain reset.
- s_valid  input  1  upstream beat valid.
- s_data  input  D_SIZE  upstream beat data.
- s_ready  output  1  upstream may transfer (registered).
- full  input  1  full flag from FIFO write controller.
- sync_rd_ptr  input  P_SIZE  gray read pointer, already 2-flop synced into w_clk.
- w_inc  output  1  FIFO write strobe.
- w_data  output  D_SIZE  FIFO write data, valid while w_inc=1.
- fill_level  output  P_SIZE  FIFO entries in use as seen from the write domain, 0..DEPTH.
- almost_full  output  1  fill_level >= AF_THRESH.

Behaviour:
- Clock w_clk, reset w_rstn, asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - buffer count 0; wr_cnt 0.
  - s_ready 0, rising to 1 on the first w_clk edge after reset release.
  - w_inc 0; w_data 0; fill_level 0; almost_full 0.
- Upstream handshake:
  - A beat transfers on a rising edge when s_valid=1 and s_ready=1.
  - s_data is captured into the buffer tail at that edge.
  - s_valid and s_data may change freely while s_ready=0.
- Skid buffer:
  - 2 entries, strict FIFO order; the head entry always drives w_data. w_data holds the last head value when empty.
  - Next s_ready = (next buffer count < 2), registered.
  - Push and pop on the same edge leave the count unchanged; the pushed beat goes behind the current head.
- Gray decode:
  - rd_bin[P_SIZE-1] = sync_rd_ptr[P_SIZE-1].
  - rd_bin[i] = rd_bin[i+1] XOR sync_rd_ptr[i], for i from P_SIZE-2 down to 0.
- wr_cnt:
  - P_SIZE-bit binary count, incremented (mod 2^P_SIZE) on every edge where w_inc=1 and full=0.
  - It tracks the write controller's binary pointer exactly.
- Fill level:
  - fill_level = (wr_cnt - rd_bin) mod 2^P_SIZE, combinational from registers and sync_rd_ptr.
  - It stays correct across pointer wrap, e.g. wr_cnt=1, rd_bin=13 -> 4.
  - It is pessimistic (never under-reports), because the synchronized read pointer lags.
- Write strobe:
  - w_inc = (buffer count != 0) AND (full == 0) AND (fill_level < DEPTH). Combinational on full; zero-cycle latency from full.
  - The local fill_level guard is authoritative. The controller's full is computed from a registered gray pointer that lags its binary pointer by one cycle, so it can arrive late after back-to-back writes.
  - A write takes effect at the edge where w_inc=1: wr_cnt increments and the buffer head pops.
- Latency and throughput:
  - Empty buffer, s_valid arrives -> w_inc=1 in the cycle after the transfer edge.
  - Sustained throughput is 1 beat/cycle while fill_level < DEPTH.
- almost_full: combinational compare of fill_level against AF_THRESH; informational only, with no effect on w_inc.
- Boundary cases:
  - fill_level == DEPTH or full=1: w_inc=0 and the buffer holds.
  - After 2 more upstream beats, s_ready falls on the edge that fills the buffer.
- Reset mid-operation: buffer contents are discarded, wr_cnt returns to 0, and no w_inc glitch occurs during reset. The write controller and read side must be reset together.

Test Plan:
- Reset release, s_valid held 0 -> s_ready 0 then 1 after one edge; w_inc=0; fill_level=0; almost_full=0.
- Stream 8 beats 0x10..0x17 back-to-back, sync_rd_ptr=0 -> w_inc on 8 consecutive cycles, each one cycle after its transfer, with w_data=0x10..0x17 in order. fill_level=8, almost_full=1 from fill_level 6, w_inc=0 afterwards.
- FIFO full (fill_level=8), push 3 more beats -> first 2 accepted, s_ready=0 on the edge storing the 2nd, no w_inc. Then sync_rd_ptr advances to gray(2)=0011 -> exactly 2 writes issue, in order.
- full input forced to 1 for 3 cycles with fill_level=3 and buffer non-empty -> w_inc=0 for those cycles; wr_cnt unchanged; writes resume the cycle full drops.
- Wrap-around: wr_cnt=1, sync_rd_ptr=gray(13)=1011 -> fill_level=4; with wr_cnt=1 and rd_bin=9, fill_level=8 -> w_inc blocked.
- Assert w_rstn low mid-stream with 2 beats buffered -> outputs take their reset values asynchronously; after release, no stale beat is written.

Source files
------------

// File: rtl/fifo_wr_feeder.sv
// rtl/fifo_wr_feeder.sv - write-domain stream feeder for the async FIFO write controller
// 2-entry skid buffer in front of the write port, with a local fill level computed from the decoded read pointer.
module fifo_wr_feeder #(
    parameter int D_SIZE    = 8,
    parameter int P_SIZE    = 4,
    parameter int AF_THRESH = 6
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              s_valid,
    input  logic [D_SIZE-1:0] s_data,
    output logic              s_ready,
    input  logic              full,
    input  logic [P_SIZE-1:0] sync_rd_ptr,
    output logic              w_inc,
    output logic [D_SIZE-1:0] w_data,
    output logic [P_SIZE-1:0] fill_level,
    output logic              almost_full
);

    localparam logic [P_SIZE-1:0] DEPTH_L = {1'b1, {(P_SIZE-1){1'b0}}};
    localparam logic [P_SIZE-1:0] AF_L    = P_SIZE'(AF_THRESH);

    logic [D_SIZE-1:0] buf_head;
    logic [D_SIZE-1:0] buf_tail;
    logic [1:0]        buf_cnt;
    logic [1:0]        buf_cnt_next;
    logic [P_SIZE-1:0] wr_cnt;
    logic [P_SIZE-1:0] rd_bin;
    logic              push;
    logic              pop;

    // Each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i < P_SIZE; i++) begin : g_gray_dec
        assign rd_bin[i] = ^sync_rd_ptr[P_SIZE-1:i];
    end

    assign fill_level  = wr_cnt - rd_bin;
    assign almost_full = (fill_level >= AF_L);

    // The local fill guard covers the cycle where the controller's full flag lags a write.
    assign w_inc  = (buf_cnt != 2'd0) && !full && (fill_level < DEPTH_L);
    assign w_data = buf_head;
    assign push   = s_valid && s_ready;
    assign pop    = w_inc;

    always_comb begin
        buf_cnt_next = buf_cnt;
        if (push && !pop) begin
            buf_cnt_next = buf_cnt + 2'd1;
        end else if (!push && pop) begin
            buf_cnt_next = buf_cnt - 2'd1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= 2'd0;
            s_ready  <= 1'b0;
            wr_cnt   <= '0;
        end else begin
            buf_cnt <= buf_cnt_next;
            s_ready <= (buf_cnt_next < 2'd2);
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            // Head keeps its value when the buffer drains, so w_data holds the last beat.
            if (pop) begin
                if (buf_cnt == 2'd2) begin
                    buf_head <= buf_tail;
                end else if (push) begin
                    buf_head <= s_data;
                end
            end else if (push) begin
                if (buf_cnt == 2'd0) begin
                    buf_head <= s_data;
                end else begin
                    buf_tail <= s_data;
                end
            end
        end
    end

endmodule
